// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: sequences fetch, decode, execute, memory
// and write-back over one shared memory port and a variable-latency mul/div unit.
module multicycle_sequencer #(
    parameter int WAIT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        lt_flag,
    input  logic        mem_ready,
    input  logic        md_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        mdr_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        md_start,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        ext_op,
    output logic [2:0]  alu_ctr,
    output logic        illegal_op,
    output logic        timeout_err,
    output logic [15:0] retired,
    output logic [2:0]  state
);
    // state  | meaning
    // FETCH  | read instruction at PC; load IR and PC+1 on mem_ready
    // DECODE | latch opcode, reject undefined opcodes
    // EXEC   | ALU operation, branch resolve, mul/div launch
    // MDWAIT | wait for mul/div result
    // MEM    | data access for lw/sw at ALU address
    // WB     | register file write
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MDWAIT = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_ORI  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;

    localparam int CW = $clog2(WAIT_LIMIT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_LIMIT - 1);

    logic [2:0]    stateReg;
    logic [2:0]    stateNext;
    logic [3:0]    opLatched;
    logic [CW-1:0] waitCnt;
    logic [15:0]   retiredCnt;
    logic          active;
    logic          retireInc;

    logic          isLw;
    logic          isSw;
    logic          isMulDiv;
    logic          isRType;
    logic          usesImm;
    logic [2:0]    aluCode;
    logic          dpActive;
    logic          waiting;
    logic          readyHere;
    logic          timeoutHit;

    assign isLw     = (opLatched == OP_LW);
    assign isSw     = (opLatched == OP_SW);
    assign isMulDiv = (opLatched == OP_MUL) || (opLatched == OP_DIV);
    assign isRType  = (opLatched == OP_ADD) || (opLatched == OP_SUB) || isMulDiv ||
                      (opLatched == OP_NOR) || (opLatched == OP_NAND);
    assign usesImm  = (opLatched == OP_ORI) || isLw || isSw;
    assign aluCode  = (isLw || isSw) ? 3'b000 : opLatched[2:0];

    // active stays low for the first cycle after reset so nothing moves until then
    assign dpActive = active && ((stateReg == EXEC) || (stateReg == MDWAIT) ||
                                 (stateReg == MEM)  || (stateReg == WB));
    assign waiting  = active && ((stateReg == FETCH) || (stateReg == MEM) ||
                                 (stateReg == MDWAIT));
    assign readyHere = (stateReg == MDWAIT) ? md_done : mem_ready;

    // down-counter hits zero on the WAIT_LIMIT-th cycle; a late ready still wins
    assign timeoutHit = waiting && !readyHere && (waitCnt == '0);

    always_comb begin
        stateNext   = stateReg;
        retireInc   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mdr_write   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        md_start    = 1'b0;
        reg_write   = 1'b0;
        illegal_op  = 1'b0;
        timeout_err = timeoutHit;
        reg_dst     = dpActive & isRType;
        alu_src     = dpActive & usesImm;
        ext_op      = dpActive & (isLw | isSw);
        mem_to_reg  = dpActive & isLw;
        alu_ctr     = dpActive ? aluCode : 3'b000;

        if (active) begin
            case (stateReg)
                FETCH: begin
                    mem_req = !timeoutHit;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        stateNext = DECODE;
                    end
                end
                DECODE: begin
                    if (opcode > OP_BLT) begin
                        illegal_op = 1'b1;
                        stateNext  = FETCH;
                    end else begin
                        stateNext = EXEC;
                    end
                end
                EXEC: begin
                    if (isMulDiv) begin
                        md_start  = 1'b1;
                        stateNext = MDWAIT;
                    end else if (isLw || isSw) begin
                        stateNext = MEM;
                    end else if (opLatched == OP_BLT) begin
                        pc_write  = lt_flag;
                        pc_src    = lt_flag;
                        retireInc = 1'b1;
                        stateNext = FETCH;
                    end else begin
                        stateNext = WB;
                    end
                end
                MDWAIT: begin
                    if (md_done) begin
                        stateNext = WB;
                    end else if (timeoutHit) begin
                        stateNext = FETCH;
                    end
                end
                MEM: begin
                    mem_req = !timeoutHit;
                    iord    = 1'b1;
                    mem_we  = isSw && !timeoutHit;
                    if (mem_ready) begin
                        if (isLw) begin
                            mdr_write = 1'b1;
                            stateNext = WB;
                        end else begin
                            retireInc = 1'b1;
                            stateNext = FETCH;
                        end
                    end else if (timeoutHit) begin
                        stateNext = FETCH;
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    retireInc = 1'b1;
                    stateNext = FETCH;
                end
                default: stateNext = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= FETCH;
            active     <= 1'b0;
            opLatched  <= '0;
            waitCnt    <= CNT_LOAD;
            retiredCnt <= '0;
        end else begin
            active   <= 1'b1;
            stateReg <= stateNext;
            if (active && (stateReg == DECODE)) begin
                opLatched <= opcode;
            end
            if ((stateNext != stateReg) || timeoutHit) begin
                waitCnt <= CNT_LOAD;
            end else if (waiting) begin
                waitCnt <= waitCnt - CW'(1);
            end
            if (retireInc) begin
                retiredCnt <= retiredCnt + 16'd1;
            end
        end
    end

    assign retired = retiredCnt;
    assign state   = stateReg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each instruction is expanded into an expected per-cycle
// trace of control outputs from the ISA timing rules, then replayed against the DUT.
module tb_multicycle_sequencer;
    localparam int WL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  opcode = 4'd0;
    logic        lt_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic        md_done = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, md_start;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, ext_op;
    logic [2:0]  alu_ctr;
    logic        illegal_op, timeout_err;
    logic [15:0] retired;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic req, we, iord, irw, mdrw, pcw, pcs, mds, rdst, asrc, m2r, rw, ext;
        logic [2:0] alu;
        logic ill, tmo;
    } ctl_t;

    typedef struct packed {
        logic rdy;
        logic done;
        logic lt;
        ctl_t exp;
    } step_t;

    ctl_t  obs;
    step_t q[$];
    int    total = 0;
    int    bad = 0;
    int    modelRetired = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .lt_flag(lt_flag),
        .mem_ready(mem_ready), .md_done(md_done),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src), .md_start(md_start),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .ext_op(ext_op), .alu_ctr(alu_ctr),
        .illegal_op(illegal_op), .timeout_err(timeout_err),
        .retired(retired), .state(state)
    );

    assign obs = {state, mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
                  md_start, reg_dst, alu_src, mem_to_reg, reg_write, ext_op, alu_ctr,
                  illegal_op, timeout_err};

    function automatic logic noise();
        return logic'($urandom_range(0, 1));
    endfunction

    // datapath controls an instruction holds from EXEC through WB
    function automatic ctl_t dpCtl(input logic [3:0] op, input logic [2:0] st);
        ctl_t c = '0;
        c.st   = st;
        c.rdst = (op <= 4'd3) || (op == 4'd5) || (op == 4'd6);
        c.asrc = (op == 4'd4) || (op == 4'd7) || (op == 4'd8);
        c.ext  = (op == 4'd7) || (op == 4'd8);
        c.m2r  = (op == 4'd8);
        c.alu  = ((op == 4'd7) || (op == 4'd8)) ? 3'b000 : op[2:0];
        return c;
    endfunction

    task automatic push(input logic rdy, input logic done, input logic lt, input ctl_t e);
        step_t s;
        s.rdy = rdy; s.done = done; s.lt = lt; s.exp = e;
        q.push_back(s);
    endtask

    // waiting phase in MEM (isMd=0) or MDWAIT (isMd=1): w idle cycles before ready
    task automatic waitPhase(input logic [3:0] op, input logic isMd, input int w,
                             output logic aborted);
        ctl_t c;
        int   idle = (w < WL) ? w : WL - 1;
        c = dpCtl(op, isMd ? 3'd3 : 3'd4);
        if (!isMd) begin
            c.req = 1'b1; c.iord = 1'b1; c.we = (op == 4'd7);
        end
        for (int i = 0; i < idle; i++) push(1'b0, isMd ? 1'b0 : noise(), noise(), c);
        aborted = (w >= WL);
        if (aborted) begin
            c.req = 1'b0; c.we = 1'b0; c.tmo = 1'b1;
            push(1'b0, isMd ? 1'b0 : noise(), noise(), c);
        end else begin
            c.mdrw = !isMd && (op == 4'd8);
            push(!isMd, isMd, noise(), c);
        end
    endtask

    task automatic buildInstr(input logic [3:0] op, input int fw, input logic lt,
                              input int mdw, input int mw);
        ctl_t c;
        int   left = fw;
        logic ab;
        while (left >= WL) begin
            for (int i = 0; i < WL; i++) begin
                c = '0; c.req = (i != WL - 1); c.tmo = (i == WL - 1);
                push(1'b0, noise(), noise(), c);
            end
            left -= WL;
        end
        for (int i = 0; i < left; i++) begin
            c = '0; c.req = 1'b1;
            push(1'b0, noise(), noise(), c);
        end
        c = '0; c.req = 1'b1; c.irw = 1'b1; c.pcw = 1'b1;
        push(1'b1, noise(), noise(), c);
        c = '0; c.st = 3'd1; c.ill = (op > 4'd9);
        push(1'b0, noise(), noise(), c);
        if (op > 4'd9) return;
        c = dpCtl(op, 3'd2);
        c.mds = (op == 4'd2) || (op == 4'd3);
        c.pcw = (op == 4'd9) && lt;
        c.pcs = (op == 4'd9) && lt;
        push(1'b0, noise(), lt, c);
        if (op == 4'd9) begin
            modelRetired++;
            return;
        end
        if ((op == 4'd2) || (op == 4'd3)) begin
            waitPhase(op, 1'b1, mdw, ab);
            if (ab) return;
        end else if ((op == 4'd7) || (op == 4'd8)) begin
            waitPhase(op, 1'b0, mw, ab);
            if (ab) return;
            if (op == 4'd7) begin
                modelRetired++;
                return;
            end
        end
        c = dpCtl(op, 3'd5); c.rw = 1'b1;
        push(1'b0, noise(), noise(), c);
        modelRetired++;
    endtask

    task automatic runQueue(input int limit);
        step_t s;
        int    n = 0;
        while ((q.size() > 0) && (n < limit)) begin
            s = q.pop_front();
            mem_ready = s.rdy; md_done = s.done; lt_flag = s.lt;
            @(negedge clk);
            total++;
            assert (obs === s.exp) else begin
                bad++;
                $error("FAIL trace op=%h step=%0d observed=%h expected=%h", opcode, n, obs, s.exp);
            end
            @(posedge clk); #1;
            n++;
        end
        mem_ready = 1'b0; md_done = 1'b0;
    endtask

    task automatic checkRetired(input string tag);
        total++;
        assert (retired === 16'(modelRetired)) else begin
            bad++;
            $error("FAIL retired_%s observed=%0d expected=%0d", tag, retired, modelRetired);
        end
    endtask

    task automatic doInstr(input logic [3:0] op, input int fw, input logic lt,
                           input int mdw, input int mw);
        opcode = op;
        buildInstr(op, fw, lt, mdw, mw);
        runQueue(1000);
        checkRetired("instr");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        total++;
        assert ((obs === '0) && (retired === 16'd0)) else begin
            bad++;
            $error("FAIL reset_outputs observed=%h/%0d expected=0/0", obs, retired);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        assert (mem_req === 1'b0) else begin
            bad++;
            $error("FAIL req_after_rst observed=%b expected=0", mem_req);
        end
        @(posedge clk); #1;

        doInstr(4'd0, 1, 1'b0, 0, 0);      // add
        doInstr(4'd2, 0, 1'b0, 4, 0);      // mul, done on 5th MDWAIT cycle
        doInstr(4'd8, 0, 1'b0, 0, 3);      // lw, ready after 3 idle MEM cycles
        doInstr(4'd7, 0, 1'b0, 0, 2);      // sw
        doInstr(4'd9, 0, 1'b1, 0, 0);      // blt taken
        doInstr(4'd9, 0, 1'b0, 0, 0);      // blt not taken
        doInstr(4'd12, 0, 1'b0, 0, 0);     // illegal
        doInstr(4'd0, 8, 1'b0, 0, 0);      // fetch timeout then refetch
        doInstr(4'd1, 7, 1'b0, 0, 0);      // ready in the timeout cycle wins
        doInstr(4'd8, 0, 1'b0, 0, 8);      // MEM timeout
        doInstr(4'd3, 0, 1'b0, 8, 0);      // MDWAIT timeout
        doInstr(4'd3, 0, 1'b0, 7, 0);      // done in the timeout cycle wins
        doInstr(4'd4, 2, 1'b0, 0, 0);      // ori
        doInstr(4'd6, 0, 1'b0, 0, 0);      // nand

        for (int k = 0; k < 60; k++) begin
            doInstr(4'($urandom_range(0, 15)), int'($urandom_range(0, 10)), noise(),
                    int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
        end

        // reset in the middle of MDWAIT
        opcode = 4'd2;
        buildInstr(4'd2, 0, 1'b0, 20, 0);
        runQueue(6);
        q.delete();
        #2 rst = 1'b1;
        #1;
        modelRetired = 0;
        total++;
        assert ((obs === '0) && (retired === 16'd0)) else begin
            bad++;
            $error("FAIL mid_rst observed=%h/%0d expected=0/0", obs, retired);
        end
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        assert (mem_req === 1'b0) else begin
            bad++;
            $error("FAIL req_after_mid_rst observed=%b expected=0", mem_req);
        end
        @(posedge clk); #1;
        doInstr(4'd5, 0, 1'b0, 0, 0);      // nor after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
